mem_wb_streamer: RTL and testbench



---
 rtl/mem_wb_streamer_pkg.sv | 26 ++
 rtl/mem_wb_streamer_if.sv | 33 +++
 rtl/mem_wb_streamer_fifo.sv | 64 ++++++
 rtl/mem_wb_streamer.sv | 126 ++++++++++++
 tb/tb_mem_wb_streamer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_streamer_pkg.sv
// Shared constants, FSM state type and byte-mask helper for the Mannix SRAM/DDR streamers.
package mannix_mem_pkg;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 128;
    localparam int LEN_W      = 12;
    localparam int BEAT_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wb_state_t;

    // A byte count of 0 means a full 16-byte beat.
    function automatic logic [BEAT_BYTES-1:0] last_byte_mask(input logic [3:0] nbytes);
        logic [BEAT_BYTES-1:0] mask;
        if (nbytes == 4'd0) begin
            mask = '1;
        end else begin
            mask = (BEAT_BYTES'(1) << nbytes) - BEAT_BYTES'(1);
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_wb_streamer_if.sv
// Command, SRAM read port and DDR beat stream of the write-back streamer.
interface mem_wb_streamer_if;
    import mannix_mem_pkg::*;

    logic                  cmd_start;
    logic [ADDR_W-1:0]     cmd_base_addr;
    logic [LEN_W-1:0]      cmd_len;
    logic [3:0]            cmd_last_bytes;
    logic                  busy;
    logic                  done;
    logic                  cmd_err;
    logic                  sram_rd_en;
    logic [ADDR_W-1:0]     sram_rd_addr;
    logic [DATA_W-1:0]     sram_rd_data;
    logic                  ddr_valid;
    logic                  ddr_ready;
    logic [DATA_W-1:0]     ddr_data;
    logic                  ddr_last;
    logic [BEAT_BYTES-1:0] ddr_byte_en;

    modport slave (
        input  cmd_start, cmd_base_addr, cmd_len, cmd_last_bytes, sram_rd_data, ddr_ready,
        output busy, done, cmd_err, sram_rd_en, sram_rd_addr,
               ddr_valid, ddr_data, ddr_last, ddr_byte_en
    );

    modport master (
        output cmd_start, cmd_base_addr, cmd_len, cmd_last_bytes, sram_rd_data, ddr_ready,
        input  busy, done, cmd_err, sram_rd_en, sram_rd_addr,
               ddr_valid, ddr_data, ddr_last, ddr_byte_en
    );

endinterface

// File: rtl/mem_wb_streamer_fifo.sv
// Small synchronous FIFO holding SRAM read data until the DDR side accepts it.
module mem_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: an entry is only observed after it has been pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_wb_streamer.sv
// SRAM-to-DDR write-back streamer: reads a contiguous word run and emits it as a beat stream.
module mem_wb_streamer
    import mannix_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_wb_streamer_if.slave   bus_if
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [3:0]        lb_q, lb_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              inflight_q;
    logic              cmd_err_q;

    logic              rd_en;
    logic              wb_done;
    logic              credit_ok;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              beat_vld;
    logic              beat_pop;
    logic              beat_last;

    mem_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (bus_if.sram_rd_data),
        .pop_i       (beat_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // Credit uses registered terms only, so ddr_ready never reaches sram_rd_en.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);

    assign beat_vld  = fifo_count != '0;
    assign beat_pop  = beat_vld && bus_if.ddr_ready;
    assign beat_last = beat_vld && (tx_cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        lb_d     = lb_q;
        rd_cnt_d = rd_cnt_q;
        tx_cnt_d = tx_cnt_q;
        rd_en    = 1'b0;
        wb_done  = 1'b0;
        if (beat_pop) tx_cnt_d = tx_cnt_q + LEN_W'(1);
        case (state_q)
            IDLE: begin
                if (bus_if.cmd_start) begin
                    base_d   = bus_if.cmd_base_addr;
                    len_d    = bus_if.cmd_len;
                    lb_d     = bus_if.cmd_last_bytes;
                    rd_cnt_d = '0;
                    tx_cnt_d = '0;
                    state_d  = (bus_if.cmd_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                    if (rd_cnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Covers len==0 too: tx_cnt starts at 0 and matches immediately.
                if (tx_cnt_q == len_q) begin
                    wb_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            lb_q       <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            inflight_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            lb_q       <= lb_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            inflight_q <= rd_en;
            cmd_err_q  <= bus_if.cmd_start && (state_q != IDLE);
        end
    end

    assign bus_if.busy         = state_q != IDLE;
    assign bus_if.done         = wb_done;
    assign bus_if.cmd_err      = cmd_err_q;
    assign bus_if.sram_rd_en   = rd_en;
    assign bus_if.sram_rd_addr = rd_en ? (base_q + ADDR_W'(rd_cnt_q)) : '0;
    assign bus_if.ddr_valid    = beat_vld;
    assign bus_if.ddr_data     = beat_vld ? fifo_head : '0;
    assign bus_if.ddr_last     = beat_last;
    assign bus_if.ddr_byte_en  = !beat_vld ? '0 :
                                 (beat_last ? last_byte_mask(lb_q) : '1);

endmodule

// File: tb/tb_mem_wb_streamer.sv
// Randomized bench for mem_wb_streamer with a queue-based beat model and SRAM responder.
module tb_mem_wb_streamer;
    import mannix_mem_pkg::*;

    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [DATA_W-1:0]     data;
        logic                  last;
        logic [BEAT_BYTES-1:0] be;
    } beat_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   rdy_mode;

    mem_wb_streamer_if bus ();

    mem_wb_streamer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    beat_t exp_q[$];
    int    addr_log[$];
    int    m_active, m_base, m_len, m_rd, m_pop, m_cyc;
    int    err_due = -1;
    int    n_err_seen;
    int    first_rd_rel, first_vld_rel, last_rel, done_rel;
    logic [BEAT_BYTES-1:0] last_be;
    beat_t mon_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {13'h0, a};
        return {w * 32'h9E3779B1, w ^ 32'hDEADBEEF, w + 32'h01234567, ~w};
    endfunction

    function automatic logic [BEAT_BYTES-1:0] exp_be(input int nb, input bit is_last);
        int n;
        if (!is_last) return 16'hFFFF;
        n = (nb == 0) ? 16 : nb;
        return (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] expv);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, expv, $time);
    endtask

    // SRAM responder: data appears the cycle after the read request.
    always @(posedge clk) begin
        if (bus.sram_rd_en) bus.sram_rd_data <= sram_word(bus.sram_rd_addr);
    end

    initial begin
        bus.ddr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.ddr_ready = 1'b1;
                1:       bus.ddr_ready = ~bus.ddr_ready;
                default: bus.ddr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: checks every output against the model each cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk(bus.cmd_err == (cyc == err_due), "cmd_err", 128'(bus.cmd_err), 128'(cyc == err_due));
            if (bus.cmd_err) n_err_seen++;
            if (bus.sram_rd_en) begin
                chk(m_active != 0 && m_rd < m_len, "rd_extra", 128'(m_rd), 128'(m_len));
                chk(bus.sram_rd_addr == ADDR_W'(m_base + m_rd), "rd_addr",
                    128'(bus.sram_rd_addr), 128'(ADDR_W'(m_base + m_rd)));
                if (m_rd == 0) first_rd_rel = cyc - m_cyc;
                addr_log.push_back(int'(bus.sram_rd_addr));
                m_rd++;
                chk((m_rd - m_pop) <= FIFO_DEPTH, "outstanding", 128'(m_rd - m_pop), 128'(FIFO_DEPTH));
            end
            if (bus.ddr_valid) begin
                if (first_vld_rel < 0) first_vld_rel = cyc - m_cyc;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "beat_extra", bus.ddr_data, '0);
                end else begin
                    mon_b = exp_q[0];
                    chk(bus.ddr_data == mon_b.data, "ddr_data", bus.ddr_data, mon_b.data);
                    chk(bus.ddr_last == mon_b.last, "ddr_last", 128'(bus.ddr_last), 128'(mon_b.last));
                    chk(bus.ddr_byte_en == mon_b.be, "ddr_byte_en", 128'(bus.ddr_byte_en), 128'(mon_b.be));
                    if (bus.ddr_ready) begin
                        void'(exp_q.pop_front());
                        m_pop++;
                        if (bus.ddr_last) begin
                            last_rel = cyc - m_cyc;
                            last_be  = bus.ddr_byte_en;
                        end
                    end
                end
            end
            if (bus.done) begin
                chk(m_active != 0 && exp_q.size() == 0 && m_pop == m_len && !bus.ddr_valid,
                    "done_state", 128'(m_pop), 128'(m_len));
                done_rel = cyc - m_cyc;
                m_active = 0;
            end
        end
    end

    task automatic issue(input int b, input int l, input int lb, input bit accept);
        beat_t nb;
        @(posedge clk);
        #1;
        bus.cmd_start      = 1'b1;
        bus.cmd_base_addr  = ADDR_W'(b);
        bus.cmd_len        = LEN_W'(l);
        bus.cmd_last_bytes = 4'(lb);
        if (accept) begin
            m_active = 1; m_base = b; m_len = l; m_rd = 0; m_pop = 0; m_cyc = cyc;
            first_rd_rel = -1; first_vld_rel = -1; last_rel = -1; done_rel = -1; last_be = '0;
            addr_log.delete();
            for (int i = 0; i < l; i++) begin
                nb.data = sram_word(ADDR_W'(b + i));
                nb.last = (i == l - 1);
                nb.be   = exp_be(lb & 15, nb.last);
                exp_q.push_back(nb);
            end
        end else begin
            err_due = cyc + 1;
        end
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && m_active != 0; i++) @(posedge clk);
        chk(m_active == 0, "done_timeout", 128'(m_active), '0);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(!bus.busy && !bus.done && !bus.cmd_err && !bus.sram_rd_en, {tag, "_ctl"},
            128'({bus.busy, bus.done, bus.cmd_err, bus.sram_rd_en}), '0);
        chk(bus.sram_rd_addr == '0, {tag, "_addr"}, 128'(bus.sram_rd_addr), '0);
        chk(!bus.ddr_valid && !bus.ddr_last && bus.ddr_byte_en == '0, {tag, "_ddr"},
            128'({bus.ddr_valid, bus.ddr_last, bus.ddr_byte_en}), '0);
        chk(bus.ddr_data == '0, {tag, "_data"}, bus.ddr_data, '0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, base;
        rst_n = 1'b0;
        rdy_mode = 0;
        m_active = 0;
        n_err_seen = 0;
        bus.cmd_start = 1'b0;
        bus.cmd_base_addr = '0;
        bus.cmd_len = '0;
        bus.cmd_last_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // base 0x10, len 4, full beats, ready high
        issue(32'h10, 4, 0, 1);
        chk(bus.busy == 1'b1, "t1_busy_c1", 128'(bus.busy), 128'(1));
        chk(bus.sram_rd_en && bus.sram_rd_addr == 19'h10, "t1_rd_c1", 128'(bus.sram_rd_addr), 128'h10);
        wait_idle(100);
        chk(first_rd_rel == 1, "t1_first_rd", 128'(first_rd_rel), 128'(1));
        chk(first_vld_rel == 3, "t1_first_vld", 128'(first_vld_rel), 128'(3));
        chk(last_rel == 6, "t1_last_cyc", 128'(last_rel), 128'(6));
        chk(done_rel == 7, "t1_done_cyc", 128'(done_rel), 128'(7));
        chk(m_pop == 4, "t1_beats", 128'(m_pop), 128'(4));
        chk(last_be == 16'hFFFF, "t1_last_be", 128'(last_be), 128'hFFFF);

        // ready toggling, partial last beat
        rdy_mode = 1;
        issue(32'h200, 3, 5, 1);
        wait_idle(100);
        chk(m_pop == 3, "t2_beats", 128'(m_pop), 128'(3));
        chk(last_be == 16'h001F, "t2_last_be", 128'(last_be), 128'h1F);
        rdy_mode = 0;

        // address wrap
        issue(32'h7FFFE, 4, 0, 1);
        wait_idle(100);
        chk(addr_log.size() == 4, "t3_nreads", 128'(addr_log.size()), 128'(4));
        if (addr_log.size() == 4) begin
            chk(addr_log[0] == 32'h7FFFE, "t3_a0", 128'(addr_log[0]), 128'h7FFFE);
            chk(addr_log[1] == 32'h7FFFF, "t3_a1", 128'(addr_log[1]), 128'h7FFFF);
            chk(addr_log[2] == 32'h00000, "t3_a2", 128'(addr_log[2]), 128'h0);
            chk(addr_log[3] == 32'h00001, "t3_a3", 128'(addr_log[3]), 128'h1);
        end

        // zero-length command
        issue(32'h55, 0, 3, 1);
        chk(bus.busy && bus.done, "t4_busy_done_c1", 128'({bus.busy, bus.done}), 128'b11);
        @(posedge clk);
        #1;
        chk(!bus.busy, "t4_busy_c2", 128'(bus.busy), '0);
        wait_idle(10);
        chk(first_rd_rel == -1 && first_vld_rel == -1, "t4_no_traffic",
            128'(first_rd_rel != -1 || first_vld_rel != -1), '0);

        // command strobe while busy
        n_err_seen = 0;
        issue(32'h300, 8, 9, 1);
        repeat (2) @(posedge clk);
        issue(32'h999, 2, 0, 0);
        wait_idle(100);
        chk(m_pop == 8, "t5_beats", 128'(m_pop), 128'(8));
        chk(n_err_seen == 1, "t5_err_pulses", 128'(n_err_seen), 128'(1));
        chk(last_be == 16'h01FF, "t5_last_be", 128'(last_be), 128'h1FF);

        // asynchronous reset mid-command
        issue(32'h400, 6, 0, 1);
        for (int i = 0; i < 50 && m_pop < 2; i++) @(posedge clk);
        chk(m_pop >= 2, "t6_wait_beats", 128'(m_pop), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        exp_q.delete();
        m_active = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'h500, 2, 7, 1);
        wait_idle(100);
        chk(m_pop == 2, "t6_after_beats", 128'(m_pop), 128'(2));
        chk(last_be == 16'h007F, "t6_last_be", 128'(last_be), 128'h7F);

        // randomized commands under random back-pressure
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            len  = int'($urandom_range(0, 20));
            base = ($urandom_range(0, 3) == 0) ? 32'h7FFF0 + int'($urandom_range(0, 15))
                                               : int'($urandom_range(0, 32'h7FFFF));
            issue(base, len, int'($urandom_range(0, 15)), 1);
            wait_idle(2000);
            chk(m_pop == len, "rand_beats", 128'(m_pop), 128'(len));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
